dmem_req_ctrl: RTL and testbench

//  Sequences the data-memory accesses issued by the EX stage onto a split request/response

---
 rtl/dmem_req_ctrl_pkg.sv | 63 ++++++
 rtl/dmem_req_ctrl_load_ext.sv | 35 +++
 rtl/dmem_req_ctrl.sv | 136 +++++++++++++
 tb/tb_dmem_req_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_req_ctrl_pkg.sv
// Shared types and constants for the data-memory request controller.
package dmem_req_ctrl_pkg;

   localparam int unsigned STALL_W       = 6;
   localparam int unsigned STALL_MEM_BIT = 3;
   localparam logic        NO_STOP       = 1'b0;
   localparam logic        STOP          = 1'b1;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   typedef enum logic [2:0] {
      LD_W  = 3'b000,
      LD_B  = 3'b001,
      LD_BU = 3'b010,
      LD_H  = 3'b011,
      LD_HU = 3'b100
   } ld_type_e;

   typedef enum logic [1:0] {
      DM_IDLE = 2'd0,
      DM_REQ  = 2'd1,
      DM_WAIT = 2'd2,
      DM_DONE = 2'd3
   } dm_state_e;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } bus_size_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] wstrb;
      logic [DATA_W-1:0] wdata;
      logic [2:0]        ld_type;
      logic [1:0]        size;
   } dmem_req_t;

   // Stores size from their strobes, loads from their type.
   function automatic logic [1:0] req_size(input logic [STRB_W-1:0] wstrb,
                                           input logic [2:0]        ld_type);
      logic [1:0] size;
      size = SIZE_W;
      if (|wstrb) begin
         case (wstrb)
            4'b1111:          size = SIZE_W;
            4'b0011, 4'b1100: size = SIZE_H;
            default:          size = SIZE_B;
         endcase
      end else begin
         case (ld_type)
            LD_B, LD_BU: size = SIZE_B;
            LD_H, LD_HU: size = SIZE_H;
            default:     size = SIZE_W;
         endcase
      end
      return size;
   endfunction

endpackage

// File: rtl/dmem_req_ctrl_load_ext.sv
// Lane select and sign/zero extension of raw bus read data.
module dmem_req_ctrl_load_ext
   import dmem_req_ctrl_pkg::*;
(
   input  logic [2:0]        ld_type,
   input  logic [1:0]        lane,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (lane)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      data_c = rdata;
      case (ld_type)
         LD_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   data_c = {24'd0, byte_sel};
         LD_H:    data_c = {{16{half_sel[15]}}, half_sel};
         LD_HU:   data_c = {16'd0, half_sel};
         default: data_c = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Sequences one EX-stage memory access at a time onto a split req/addr_ok/data_ok bus,
// stalling the pipeline until the response (or a timeout) arrives.
module dmem_req_ctrl
   import dmem_req_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               ex_mem_en,
   input  logic [STRB_W-1:0]  ex_mem_wen,
   input  logic [2:0]         ex_mem_ld_type,
   input  logic [ADDR_W-1:0]  ex_mem_addr,
   input  logic [DATA_W-1:0]  ex_mem_wdata,
   output logic               bus_req,
   output logic               bus_wr,
   output logic [1:0]         bus_size,
   output logic [ADDR_W-1:0]  bus_addr,
   output logic [STRB_W-1:0]  bus_wstrb,
   output logic [DATA_W-1:0]  bus_wdata,
   input  logic               bus_addr_ok,
   input  logic               bus_data_ok,
   input  logic [DATA_W-1:0]  bus_rdata,
   output logic               stallreq_mem,
   output logic [DATA_W-1:0]  mem_rdata,
   output logic               mem_done,
   output logic               bus_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   dm_state_e         state;
   dmem_req_t         req_q;
   dmem_req_t         new_req;
   logic [CNT_W-1:0]  tmo_cnt;
   logic [DATA_W-1:0] ext_data;
   logic [DATA_W-1:0] result;
   logic              advance;
   logic              timeout;
   logic              unused_stall;

   assign new_req = '{addr:    ex_mem_addr,
                      wstrb:   ex_mem_wen,
                      wdata:   ex_mem_wdata,
                      ld_type: ex_mem_ld_type,
                      size:    req_size(ex_mem_wen, ex_mem_ld_type)};

   assign advance      = (stall[STALL_MEM_BIT] == NO_STOP);
   assign timeout      = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign unused_stall = ^{stall[STALL_W-1:STALL_MEM_BIT+1], stall[STALL_MEM_BIT-1:0]};

   dmem_req_ctrl_load_ext u_load_ext (
      .ld_type (req_q.ld_type),
      .lane    (req_q.addr[1:0]),
      .rdata   (bus_rdata),
      .data_c  (ext_data)
   );

   // Stores complete with a zero result.
   assign result = (|req_q.wstrb) ? '0 : ext_data;

   // Bus payload comes straight from the captured request registers.
   assign bus_req   = (state == DM_REQ);
   assign bus_wr    = |req_q.wstrb;
   assign bus_size  = req_q.size;
   assign bus_addr  = req_q.addr;
   assign bus_wstrb = req_q.wstrb;
   assign bus_wdata = req_q.wdata;
   assign mem_done  = (state == DM_DONE);

   // Must rise in the issue cycle, before the FSM has left IDLE.
   assign stallreq_mem = ((state == DM_IDLE) && ex_mem_en) ||
                         (state == DM_REQ) || (state == DM_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= DM_IDLE;
         req_q     <= '0;
         tmo_cnt   <= '0;
         mem_rdata <= '0;
         bus_err   <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            DM_IDLE: begin
               if (ex_mem_en) begin
                  req_q   <= new_req;
                  tmo_cnt <= '0;
                  state   <= DM_REQ;
               end
            end
            DM_REQ: begin
               if (bus_addr_ok && bus_data_ok) begin
                  mem_rdata <= result;
                  state     <= DM_DONE;
               end else if (timeout) begin
                  bus_err   <= 1'b1;
                  mem_rdata <= '0;
                  state     <= DM_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
                  if (bus_addr_ok) begin
                     state <= DM_WAIT;
                  end
               end
            end
            DM_WAIT: begin
               if (bus_data_ok) begin
                  mem_rdata <= result;
                  state     <= DM_DONE;
               end else if (timeout) begin
                  bus_err   <= 1'b1;
                  mem_rdata <= '0;
                  state     <= DM_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            DM_DONE: begin
               if (advance) begin
                  if (ex_mem_en) begin
                     req_q   <= new_req;
                     tmo_cnt <= '0;
                     state   <= DM_REQ;
                  end else begin
                     state <= DM_IDLE;
                  end
               end
            end
            default: state <= DM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Randomized and directed bench for dmem_req_ctrl against a transaction-level model.
module tb_dmem_req_ctrl;
   import dmem_req_ctrl_pkg::*;

   localparam int unsigned TMO = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [STALL_W-1:0] stall = '0;
   logic               ex_mem_en = 1'b0;
   logic [3:0]         ex_mem_wen = '0;
   logic [2:0]         ex_mem_ld_type = '0;
   logic [31:0]        ex_mem_addr = '0;
   logic [31:0]        ex_mem_wdata = '0;
   logic               bus_req, bus_wr;
   logic [1:0]         bus_size;
   logic [31:0]        bus_addr, bus_wdata, bus_rdata = '0;
   logic [3:0]         bus_wstrb;
   logic               bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
   logic               stallreq_mem, mem_done, bus_err;
   logic [31:0]        mem_rdata;

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  in_done = 1'b0;

   dmem_req_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen), .ex_mem_ld_type(ex_mem_ld_type),
      .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .stallreq_mem(stallreq_mem), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] b, h;
      int          bsh, hsh;
      bsh = 8 * int'(a[1:0]);
      hsh = 16 * int'(a[1]);
      b = (rd >> bsh) & 32'h0000_00FF;
      h = (rd >> hsh) & 32'h0000_FFFF;
      case (t)
         LD_B:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
         LD_BU:   return b;
         LD_H:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         LD_HU:   return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [1:0] ref_size(input logic [3:0] wen, input logic [2:0] t);
      if (wen != 4'd0) begin
         case ($countones(wen))
            4:       return 2'd2;
            2:       return 2'd1;
            default: return 2'd0;
         endcase
      end
      if (t == LD_B || t == LD_BU) return 2'd0;
      if (t == LD_H || t == LD_HU) return 2'd1;
      return 2'd2;
   endfunction

   // One complete access: issue, a_dly refused REQ cycles, d_dly WAIT cycles, hold+1 DONE cycles.
   task automatic access(input logic [3:0] wen, input logic [2:0] lt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int a_dly, input int d_dly, input int hold);
      logic [31:0] exp_rd;
      exp_rd = (wen != 4'd0) ? 32'd0 : ref_load(lt, addr, rdata);
      stall = STALL_W'($urandom);
      stall[STALL_MEM_BIT] = NO_STOP;
      ex_mem_en = 1'b1; ex_mem_wen = wen; ex_mem_ld_type = lt;
      ex_mem_addr = addr; ex_mem_wdata = wdata;
      @(negedge clk);
      check("issue_stallreq", 32'(stallreq_mem), in_done ? 32'd0 : 32'd1);
      if (in_done) check("b2b_done", 32'(mem_done), 32'd1);
      tick;
      ex_mem_en = 1'b0; ex_mem_addr = $urandom; ex_mem_wdata = $urandom; ex_mem_wen = 4'(~wen);
      for (int i = 0; i <= a_dly; i++) begin
         stall = STALL_W'($urandom);
         bus_addr_ok = (i == a_dly);
         bus_data_ok = (i == a_dly) ? (d_dly == 0) : 1'($urandom_range(0, 1));
         bus_rdata   = (i == a_dly) ? rdata : $urandom;
         @(negedge clk);
         check("req_valid", 32'(bus_req), 32'd1);
         check("req_stall", 32'(stallreq_mem), 32'd1);
         check("req_addr", bus_addr, addr);
         check("req_wr", 32'(bus_wr), (wen != 4'd0) ? 32'd1 : 32'd0);
         check("req_size", 32'(bus_size), 32'(ref_size(wen, lt)));
         check("req_wstrb", 32'(bus_wstrb), 32'(wen));
         check("req_wdata", bus_wdata, wdata);
         check("req_not_done", 32'(mem_done), 32'd0);
         tick;
      end
      bus_addr_ok = 1'b0;
      for (int j = 1; j <= d_dly; j++) begin
         bus_data_ok = (j == d_dly);
         bus_rdata   = (j == d_dly) ? rdata : $urandom;
         @(negedge clk);
         check("wait_req_low", 32'(bus_req), 32'd0);
         check("wait_stall", 32'(stallreq_mem), 32'd1);
         tick;
      end
      bus_data_ok = 1'b0; bus_rdata = $urandom;
      stall = STALL_W'($urandom);
      stall[STALL_MEM_BIT] = STOP;
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         check("done_flag", 32'(mem_done), 32'd1);
         check("done_stall", 32'(stallreq_mem), 32'd0);
         check("done_rdata", mem_rdata, exp_rd);
         check("done_no_err", 32'(bus_err), 32'd0);
         check("done_req_low", 32'(bus_req), 32'd0);
         tick;
      end
      in_done = 1'b1;
   endtask

   // Let DONE drain to IDLE with no new access.
   task automatic release_idle;
      stall = '0;
      ex_mem_en = 1'b0;
      @(negedge clk);
      check("release_done", 32'(mem_done), 32'd1);
      tick;
      @(negedge clk);
      check("idle_done", 32'(mem_done), 32'd0);
      check("idle_req", 32'(bus_req), 32'd0);
      check("idle_stall", 32'(stallreq_mem), 32'd0);
      tick;
      in_done = 1'b0;
   endtask

   task automatic timeout_access;
      stall = '0;
      ex_mem_en = 1'b1; ex_mem_wen = 4'd0; ex_mem_ld_type = LD_W;
      ex_mem_addr = 32'h0000_0200; ex_mem_wdata = '0;
      @(negedge clk);
      check("tmo_issue", 32'(stallreq_mem), 32'd1);
      tick;
      ex_mem_en = 1'b0;
      for (int c = 0; c < int'(TMO); c++) begin
         bus_addr_ok = (c == 2);
         bus_data_ok = 1'b0;
         @(negedge clk);
         check("tmo_pending_stall", 32'(stallreq_mem), 32'd1);
         check("tmo_no_err_yet", 32'(bus_err), 32'd0);
         check("tmo_req", 32'(bus_req), (c <= 2) ? 32'd1 : 32'd0);
         tick;
      end
      bus_addr_ok = 1'b0;
      stall[STALL_MEM_BIT] = STOP;
      @(negedge clk);
      check("tmo_err_pulse", 32'(bus_err), 32'd1);
      check("tmo_done", 32'(mem_done), 32'd1);
      check("tmo_rdata_zero", mem_rdata, 32'd0);
      check("tmo_stall_low", 32'(stallreq_mem), 32'd0);
      tick;
      bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("tmo_err_one_cycle", 32'(bus_err), 32'd0);
      check("stray_still_done", 32'(mem_done), 32'd1);
      tick;
      bus_data_ok = 1'b0;
      @(negedge clk);
      check("stray_ignored", mem_rdata, 32'd0);
      tick;
      in_done = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  wens [7];
      logic [3:0]  w;
      logic [2:0]  lt;
      logic [31:0] a;
      wens = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

      #12;
      check("rst_req", 32'(bus_req), 32'd0);
      check("rst_stall", 32'(stallreq_mem), 32'd0);
      check("rst_done", 32'(mem_done), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_err", 32'(bus_err), 32'd0);
      check("rst_size", 32'(bus_size), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick;

      // Word load, accepted in the first REQ cycle, data two cycles later.
      access(4'b0000, LD_W, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 2, 0);
      release_idle();
      access(4'b0000, LD_B,  32'h0000_0103, 32'd0, 32'h8011_2233, 1, 1, 1);
      release_idle();
      access(4'b0000, LD_BU, 32'h0000_0103, 32'd0, 32'h8011_2233, 0, 1, 0);
      release_idle();
      access(4'b0000, LD_H,  32'h0000_0102, 32'd0, 32'h8011_2233, 0, 3, 0);
      release_idle();
      access(4'b0000, LD_HU, 32'h0000_0100, 32'd0, 32'h0000_F00D, 2, 0, 0);
      release_idle();
      // Byte store held across three refused REQ cycles.
      access(4'b0100, LD_W, 32'h0000_0102, 32'h5555_5555, 32'hFFFF_FFFF, 3, 1, 0);
      release_idle();
      // Same-cycle addr_ok/data_ok, then back-to-back without an IDLE cycle.
      access(4'b0000, LD_W, 32'h0000_0300, 32'd0, 32'h0BAD_F00D, 0, 0, 0);
      access(4'b0000, LD_HU, 32'h0000_0302, 32'd0, 32'hABCD_1234, 0, 0, 0);
      release_idle();

      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            w  = wens[$urandom_range(0, 6)];
            lt = 3'($urandom_range(0, 4));
         end else begin
            w  = 4'd0;
            lt = 3'($urandom_range(0, 4));
            if (lt == LD_W) a[1:0] = 2'b00;
            if (lt == LD_H || lt == LD_HU) a[0] = 1'b0;
         end
         access(w, lt, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 0) release_idle();
      end
      if (in_done) release_idle();

      // Make mem_rdata nonzero so the timeout's zeroing is observable.
      access(4'b0000, LD_W, 32'h0000_0400, 32'd0, 32'h1234_5678, 0, 1, 0);
      release_idle();
      timeout_access();
      release_idle();

      // Async reset while a store sits in WAIT.
      access(4'b0000, LD_W, 32'h0000_0500, 32'd0, 32'h8765_4321, 0, 0, 0);
      release_idle();
      stall = '0;
      ex_mem_en = 1'b1; ex_mem_wen = 4'b1111; ex_mem_ld_type = LD_W;
      ex_mem_addr = 32'h0000_0604; ex_mem_wdata = 32'hA5A5_A5A5;
      tick;
      ex_mem_en = 1'b0;
      bus_addr_ok = 1'b1;
      tick;
      bus_addr_ok = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_req", 32'(bus_req), 32'd0);
      check("arst_wr", 32'(bus_wr), 32'd0);
      check("arst_addr", bus_addr, 32'd0);
      check("arst_wstrb", 32'(bus_wstrb), 32'd0);
      check("arst_wdata", bus_wdata, 32'd0);
      check("arst_size", 32'(bus_size), 32'd0);
      check("arst_stall", 32'(stallreq_mem), 32'd0);
      check("arst_done", 32'(mem_done), 32'd0);
      check("arst_rdata", mem_rdata, 32'd0);
      check("arst_err", 32'(bus_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus_data_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick;
         @(negedge clk);
         check("post_rst_req", 32'(bus_req), 32'd0);
         check("post_rst_stall", 32'(stallreq_mem), 32'd0);
         check("post_rst_done", 32'(mem_done), 32'd0);
      end
      bus_data_ok = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
